key_debounce_encode: RTL and testbench

KEY_DEBOUNCE_ENCODE -- requirements
Module: key_debounce_encode

---
 rtl/key_debounce_encode.sv | 105 ++++++++++
 tb/tb_key_debounce_encode.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/key_debounce_encode.sv
// Four-key debouncer: 2-flop synchronizer, per-bit debounce counter and stable
// level, plus a single-entry press-event register with overflow and press count.
module key_debounce_encode #(
  parameter int DB_LIMIT = 50000,
  parameter int CNT_W    = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key_raw,
  input  logic       evt_ready,
  input  logic       clr_ovf,
  output logic [3:0] x_clean,
  output logic       en,
  output logic       evt_valid,
  output logic [1:0] evt_code,
  output logic       ovf,
  output logic [7:0] press_cnt
);

  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(DB_LIMIT - 1);

  logic [3:0] sync1;
  logic [3:0] sync2;
  logic [3:0] stable;
  logic [3:0] update;
  logic [3:0] rise;
  logic       press;
  logic [1:0] press_code;
  logic       load;
  logic       drop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= key_raw;
      sync2 <= sync1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_bit
      logic [CNT_W-1:0] count;
      logic             level;

      // The stable level flips only after DB_LIMIT consecutive differing cycles.
      assign update[gi] = (sync2[gi] != level) && (count == CNT_TOP);
      assign stable[gi] = level;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          count <= '0;
          level <= 1'b0;
        end else if (sync2[gi] == level) begin
          count <= '0;
        end else if (update[gi]) begin
          count <= '0;
          level <= sync2[gi];
        end else begin
          count <= count + CNT_W'(1);
        end
      end
    end
  endgenerate

  // A press is a 0->1 update of a stable bit; releases never raise events.
  assign rise  = update & sync2;
  assign press = |rise;

  always_comb begin
    press_code = 2'd0;
    if (rise[3])      press_code = 2'd3;
    else if (rise[2]) press_code = 2'd2;
    else if (rise[1]) press_code = 2'd1;
  end

  assign load = press && (!evt_valid || evt_ready);
  assign drop = press && evt_valid && !evt_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      evt_valid <= 1'b0;
      evt_code  <= 2'd0;
      ovf       <= 1'b0;
      press_cnt <= 8'd0;
    end else begin
      if (load) begin
        evt_valid <= 1'b1;
        evt_code  <= press_code;
        press_cnt <= press_cnt + 8'd1;
      end else if (evt_valid && evt_ready) begin
        evt_valid <= 1'b0;
      end
      // A drop on the same edge as a clear keeps the flag set.
      if (drop)         ovf <= 1'b1;
      else if (clr_ovf) ovf <= 1'b0;
    end
  end

  assign x_clean = stable;
  assign en      = |stable;

endmodule

// File: tb/tb_key_debounce_encode.sv
// Directed bench for key_debounce_encode with DB_LIMIT = 4; expected values
// are hand-derived (a level set before edge 0 appears on x_clean after edge 5).
module tb_key_debounce_encode;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] key_raw = 4'd0;
  logic       evt_ready = 1'b0;
  logic       clr_ovf = 1'b0;
  logic [3:0] x_clean;
  logic       en;
  logic       evt_valid;
  logic [1:0] evt_code;
  logic       ovf;
  logic [7:0] press_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  key_debounce_encode #(.DB_LIMIT(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .key_raw(key_raw), .evt_ready(evt_ready),
    .clr_ovf(clr_ovf), .x_clean(x_clean), .en(en), .evt_valid(evt_valid),
    .evt_code(evt_code), .ovf(ovf), .press_cnt(press_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
      $display("ok   %s: %0h", tag, got);
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    key_raw   = 4'd0;
    evt_ready = 1'b0;
    clr_ovf   = 1'b0;
    rst       = 1'b1;
    ticks(1);
    rst = 1'b0;
  endtask

  initial begin
    #2;
    check("rst_x_clean", 32'(x_clean), 32'd0);
    check("rst_en", 32'(en), 32'd0);
    check("rst_valid", 32'(evt_valid), 32'd0);
    check("rst_cnt", 32'(press_cnt), 32'd0);
    do_reset();

    // Single key press latency
    key_raw = 4'b0100;
    ticks(5);
    check("lat_edge4_x", 32'(x_clean), 32'd0);
    check("lat_edge4_valid", 32'(evt_valid), 32'd0);
    ticks(1);
    check("lat_edge5_x", 32'(x_clean), 32'b0100);
    check("lat_en", 32'(en), 32'd1);
    check("lat_valid", 32'(evt_valid), 32'd1);
    check("lat_code", 32'(evt_code), 32'd2);
    check("lat_cnt", 32'(press_cnt), 32'd1);
    key_raw = 4'd0;
    ticks(6);
    check("release_x", 32'(x_clean), 32'd0);
    check("release_en", 32'(en), 32'd0);
    check("release_cnt", 32'(press_cnt), 32'd1);
    check("release_ovf", 32'(ovf), 32'd0);
    evt_ready = 1'b1;
    ticks(1);
    evt_ready = 1'b0;
    check("accept_valid", 32'(evt_valid), 32'd0);
    check("accept_code_hold", 32'(evt_code), 32'd2);

    // Short glitch on bit 0
    key_raw = 4'b0001;
    ticks(3);
    key_raw = 4'd0;
    ticks(8);
    check("glitch_x", 32'(x_clean), 32'd0);
    check("glitch_valid", 32'(evt_valid), 32'd0);
    check("glitch_cnt", 32'(press_cnt), 32'd1);

    // Simultaneous rise of bits 1 and 3
    do_reset();
    key_raw = 4'b1010;
    ticks(6);
    check("multi_x", 32'(x_clean), 32'b1010);
    check("multi_code", 32'(evt_code), 32'd3);
    check("multi_valid", 32'(evt_valid), 32'd1);
    ticks(3);
    check("multi_cnt", 32'(press_cnt), 32'd1);

    // Overflow on drop, clear, set-wins
    do_reset();
    key_raw = 4'b0001;
    ticks(6);
    check("ovf_first_code", 32'(evt_code), 32'd0);
    key_raw = 4'd0;
    ticks(6);
    key_raw = 4'b0010;
    ticks(6);
    check("ovf_code_kept", 32'(evt_code), 32'd0);
    check("ovf_set", 32'(ovf), 32'd1);
    check("ovf_cnt", 32'(press_cnt), 32'd1);
    clr_ovf = 1'b1;
    ticks(1);
    clr_ovf = 1'b0;
    check("ovf_cleared", 32'(ovf), 32'd0);
    key_raw = 4'd0;
    ticks(6);
    key_raw = 4'b0010;
    ticks(5);
    clr_ovf = 1'b1;
    ticks(1);
    clr_ovf = 1'b0;
    check("ovf_set_wins", 32'(ovf), 32'd1);
    check("ovf_set_wins_cnt", 32'(press_cnt), 32'd1);

    // Accept and reload on the same edge, then wrap the counter
    do_reset();
    key_raw = 4'b0001;
    ticks(6);
    key_raw = 4'd0;
    ticks(6);
    key_raw = 4'b1000;
    ticks(5);
    evt_ready = 1'b1;
    ticks(1);
    check("reload_valid", 32'(evt_valid), 32'd1);
    check("reload_code", 32'(evt_code), 32'd3);
    check("reload_cnt", 32'(press_cnt), 32'd2);
    key_raw = 4'd0;
    ticks(6);
    check("reload_drained", 32'(evt_valid), 32'd0);
    for (int p = 0; p < 253; p++) begin
      key_raw = 4'b0001;
      ticks(6);
      key_raw = 4'd0;
      ticks(6);
    end
    check("cnt_255", 32'(press_cnt), 32'd255);
    key_raw = 4'b0001;
    ticks(6);
    check("cnt_wrap", 32'(press_cnt), 32'd0);
    check("wrap_ovf", 32'(ovf), 32'd0);
    key_raw = 4'd0;
    ticks(6);
    evt_ready = 1'b0;

    // Asynchronous reset mid-debounce
    do_reset();
    key_raw = 4'b0100;
    ticks(6);
    key_raw = 4'b0101;
    ticks(4);
    rst = 1'b1;
    #2;
    check("arst_x", 32'(x_clean), 32'd0);
    check("arst_en", 32'(en), 32'd0);
    check("arst_valid", 32'(evt_valid), 32'd0);
    check("arst_cnt", 32'(press_cnt), 32'd0);
    rst = 1'b0;
    ticks(5);
    check("arst_edge4_x", 32'(x_clean), 32'd0);
    check("arst_edge4_valid", 32'(evt_valid), 32'd0);
    ticks(1);
    check("arst_edge5_x", 32'(x_clean), 32'b0101);
    check("arst_code", 32'(evt_code), 32'd2);
    check("arst_valid_again", 32'(evt_valid), 32'd1);
    check("arst_cnt_again", 32'(press_cnt), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
